seq_mult_ctrl: RTL and testbench
================================

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; legal values are powers of two from 8 to 32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: multiplicand  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 Port: multiplier  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 Port: product  output  2*WIDTH  result register; valid while done=1 and held afterwards.
REQ-008 Port: busy  output  1  high in CALC state.
REQ-009 Port: done  output  1  one-cycle pulse, high in DONE state.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-011 IDLE with start=1 at an edge SHALL capture multiplicand internally, load product={WIDTH zeros, multiplier} and iteration counter=0, and go to CALC.
REQ-012 IDLE with start=0 SHALL hold state, product and counter unchanged.
REQ-013 Each CALC edge SHALL do one shift-add step: if product[0]=1, add the multiplicand to product[2W-1:W] as a WIDTH+1-bit sum; then shift {carry, sum, product[W-1:0]} right by one into product.
REQ-014 The adder carry SHALL never be dropped: the upper half plus carry is WIDTH+1 bits before the shift.
REQ-015 The counter SHALL increment once per CALC edge; the edge on which the counter equals WIDTH-1 SHALL perform the last step and go to DONE.
REQ-016 Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH (k+32 for the default) and busy=1 for exactly WIDTH cycles.
REQ-017 DONE SHALL go to IDLE on the next edge unconditionally; start sampled in DONE SHALL be ignored.
REQ-018 start asserted during CALC SHALL be ignored, and operand input changes during CALC SHALL not affect the result.
REQ-019 product SHALL hold its final value in IDLE until the next accepted start.
REQ-020 Zero operands SHALL still take the full WIDTH cycles; there is no early termination.

Reset
REQ-021 reset=1 at an edge SHALL force IDLE, product=0, counter=0, the internal multiplicand register=0, busy=0 and done=0, overriding start.
REQ-022 reset asserted mid-CALC SHALL abort the operation with no done pulse; the first start after reset is released SHALL behave as in REQ-011.

Configuration
REQ-023 With macro SEQ_MULT_SIGNED_EN defined, the block SHALL add input port is_signed (1 bit), captured with the operands on the accepted start edge.
REQ-024 With the macro defined and is_signed=1, the block SHALL load the magnitudes of both two's-complement operands, record sign = msb(A) XOR msb(B), and two's-complement negate product on the final CALC edge when sign=1; latency SHALL be unchanged.
REQ-025 With the macro defined and is_signed=0, or with the macro undefined (port absent), the block SHALL compute the unsigned product only.

Verification
REQ-026 For the cases below, WIDTH=32 and "edge k" is the edge at which start is accepted.
REQ-027 start with A=47, B=25 -> done high exactly in the cycle after edge k+32, product=1175, busy high for 32 cycles.
REQ-028 A=32'hFFFFFFFF, B=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001; checks the upper-half carry.
REQ-029 start with A=6, B=7, then start pulsed again with A=100, B=100 at cycle 5 of CALC -> product=42, single done pulse, FSM returns to IDLE.
REQ-030 reset at edge k+10 of a 123x456 operation -> no done pulse, product=0, IDLE; a following start with A=3, B=4 gives product=12 after 32 busy cycles.
REQ-031 SEQ_MULT_SIGNED_EN defined, is_signed=1, A=-3, B=5 -> product=64'hFFFFFFFFFFFFFFF1; is_signed=0 with the same bit patterns -> product=64'h00000004FFFFFFF1.

Source files
------------

// File: rtl/seq_mult_ctrl.sv
// Shift-add WIDTH x WIDTH multiplier; optional signed mode via SEQ_MULT_SIGNED_EN.
// Latency: done pulses in the cycle after edge k+WIDTH for a start accepted at edge k.
// No backpressure: start is honoured only in IDLE, ignored while busy or done.
module seq_mult_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic               is_signed,
`endif
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     mcand;
   logic                 sign;
   logic                 last;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]     a_load;
   logic [WIDTH-1:0]     b_load;
   logic                 sign_load;

   assign last = (cnt == CW'(WIDTH - 1));

   // Upper half keeps its carry so the shift never loses the top bit.
   always_comb begin
      sum = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
   end

   assign shifted = {sum, product[WIDTH-1:1]};

`ifdef SEQ_MULT_SIGNED_EN
   // Signed operands run through the unsigned datapath as magnitudes.
   always_comb begin
      a_load    = multiplicand;
      b_load    = multiplier;
      sign_load = 1'b0;
      if (is_signed) begin
         if (multiplicand[WIDTH-1]) a_load = -multiplicand;
         if (multiplier[WIDTH-1])   b_load = -multiplier;
         sign_load = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
      end
   end
`else
   assign a_load    = multiplicand;
   assign b_load    = multiplier;
   assign sign_load = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CALC;
         CALC:    if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         CALC:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         product <= '0;
         cnt     <= '0;
         mcand   <= '0;
         sign    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand   <= a_load;
                  product <= {{WIDTH{1'b0}}, b_load};
                  cnt     <= '0;
                  sign    <= sign_load;
               end
            end
            CALC: begin
               cnt <= cnt + 1'b1;
               if (last && sign) product <= -shifted;
               else              product <= shifted;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl (WIDTH=32): timing/result model plus directed vectors.
// Signed vectors are exercised only when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_mult_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          is_sig;
   logic [2*W-1:0] product;
   logic          busy;
   logic          done;

   int n_chk  = 0;
   int n_fail = 0;

   seq_mult_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .multiplicand (a),
      .multiplier   (b),
`ifdef SEQ_MULT_SIGNED_EN
      .is_signed    (is_sig),
`endif
      .product      (product),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, expv);
      end
   endtask

   // Model: an accepted start at edge acc means busy after edges acc..acc+W-1,
   // done after edge acc+W, and the arithmetic product held from then on.
   int            cyc = 0;
   int            acc = -1000;
   logic [63:0]   exp_res = '0;
   logic [63:0]   held = '0;
   logic          chk_en = 1'b0;

   function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [63:0] r;
      r = {32'b0, x} * {32'b0, y};
`ifdef SEQ_MULT_SIGNED_EN
      if (s) r = $signed({{32{x[W-1]}}, x}) * $signed({{32{y[W-1]}}, y});
`endif
      return r;
   endfunction

   always @(posedge clk) begin
      bit idle;
      cyc++;
      if (reset) begin
         acc  = -1000;
         held = '0;
      end else begin
         idle = !((cyc - 1) >= acc && (cyc - 1) <= acc + W);
         if (idle && start) begin
            acc     = cyc;
            exp_res = ref_mul(a, b, is_sig);
         end
         if (cyc == acc + W) held = exp_res;
      end
   end

   always @(negedge clk) begin
      bit eb, ed;
      if (chk_en) begin
         eb = (cyc >= acc) && (cyc <= acc + W - 1);
         ed = (cyc == acc + W);
         chk("cyc_busy", 64'(busy), 64'(eb));
         chk("cyc_done", 64'(done), 64'(ed));
         if (!eb) chk("cyc_product", product, held);
      end
   end

   task automatic run_op(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic s, input logic [63:0] lit);
      bit seen = 0;
      int busy_n = 0;
      @(posedge clk); #1;
      a = x; b = y; is_sig = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1;
         else if (busy) busy_n++;
      end
      chk({nm, "_done_seen"}, 64'(seen), 64'd1);
      chk({nm, "_busy_cycles"}, 64'(busy_n), 64'd32);
      chk({nm, "_product"}, product, lit);
      chk({nm, "_model"}, held, lit);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dn;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; is_sig = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);

      run_op("m47x25", 32'd47, 32'd25, 1'b0, 64'd1175);
      // start while in DONE must be ignored
      a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(negedge clk);
      chk("done_start_busy", 64'(busy), 64'd0);
      chk("done_start_hold", product, 64'd1175);

      run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
      run_op("zero", 32'd0, 32'd0, 1'b0, 64'd0);
      run_op("msb", 32'h8000_0000, 32'd2, 1'b0, 64'h0000_0001_0000_0000);

      // restart attempt and operand change mid-CALC
      @(posedge clk); #1 a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 a = 32'd100; b = 32'd100; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      dn = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("restart_done_pulses", 64'(dn), 64'd1);
      chk("restart_product", product, 64'd42);
      chk("restart_busy", 64'(busy), 64'd0);

      // reset at edge k+10 aborts the operation
      @(posedge clk); #1 a = 32'd123; b = 32'd456; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_done_pulses", 64'(dn), 64'd0);
      chk("abort_product", product, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      run_op("post_rst_3x4", 32'd3, 32'd4, 1'b0, 64'd12);

`ifdef SEQ_MULT_SIGNED_EN
      run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1);
      run_op("s_minxm1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
      run_op("s_7xm2", 32'd7, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF2);
`endif

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
